bus_arbiter: RTL and testbench

Owns the shared memory bus between the CPU and the DMA engine and produces the DMA's bus grant. Honours DMA bus requests with fixed DMA priority, never preempts an in-flight CPU memory access, and enforces a CPU slot between DMA bursts so cycle stealing cannot starve the CPU. Sits between the CPU core, the DMA block and the memory-port mux.

---
 rtl/bus_arbiter.sv | 124 ++++++++++++
 tb/tb_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Shared memory-bus arbiter between the CPU and the DMA engine.
// DMA has fixed priority but never preempts a CPU access and must leave a CPU slot between bursts.
module bus_arbiter #(
    parameter int CPU_SLOT = 2,
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             dma_br,
    input  logic             cpu_req,
    input  logic             cpu_mem_busy,
    output logic             bg,
    output logic             mem_sel,
    output logic             cpu_stall,
    output logic             timeout_err,
    output logic [CNT_W-1:0] grant_count
);

    localparam int CD_W   = $clog2(CPU_SLOT + 2);
    localparam int HOLD_W = $clog2(MAX_HOLD + 2);
    localparam logic [CD_W-1:0]   SLOT_INIT  = CD_W'(CPU_SLOT);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        WAIT_CPU = 2'd1,
        DMA_OWN  = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CD_W-1:0]   cooldown_q, cooldown_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  grant_count_q, grant_count_d;
    logic              bg_q, bg_d;
    logic              mem_sel_q, mem_sel_d;
    logic              cpu_stall_q, cpu_stall_d;
    logic              timeout_q, timeout_d;
    logic              slot_free;

    always_comb begin
        state_d       = state_q;
        cooldown_d    = cooldown_q;
        hold_d        = hold_q;
        grant_count_d = grant_count_q;
        timeout_d     = timeout_q;
        // An idle CPU waives its remaining slot so the DMA is never delayed for nothing.
        slot_free     = (cooldown_q == '0) || !cpu_req;

        case (state_q)
            CPU_OWN: begin
                if (cooldown_q != '0) begin
                    cooldown_d = cpu_req ? (cooldown_q - CD_W'(1)) : '0;
                end
                if (dma_br && slot_free) begin
                    cooldown_d = '0;
                    state_d    = cpu_mem_busy ? WAIT_CPU : DMA_OWN;
                end
            end
            WAIT_CPU: begin
                if (!dma_br) begin
                    state_d = CPU_OWN;
                end else if (!cpu_mem_busy) begin
                    state_d = DMA_OWN;
                end
            end
            DMA_OWN: begin
                if (!dma_br) begin
                    state_d = RELEASE;
                end else if (hold_q != HOLD_LIMIT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RELEASE: begin
                state_d    = CPU_OWN;
                cooldown_d = SLOT_INIT;
            end
            default: state_d = CPU_OWN;
        endcase

        if ((state_d == DMA_OWN) && (state_q != DMA_OWN)) begin
            grant_count_d = grant_count_q + CNT_W'(1);
            hold_d        = '0;
        end
        if (hold_d == HOLD_LIMIT) begin
            timeout_d = 1'b1;
        end

        // Outputs come straight from flops loaded with next-state decode, so bg cannot glitch.
        bg_d        = (state_d == DMA_OWN);
        mem_sel_d   = (state_d == DMA_OWN) || (state_d == RELEASE);
        cpu_stall_d = cpu_req && mem_sel_d;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= CPU_OWN;
            cooldown_q    <= '0;
            hold_q        <= '0;
            grant_count_q <= '0;
            bg_q          <= 1'b0;
            mem_sel_q     <= 1'b0;
            cpu_stall_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cooldown_q    <= cooldown_d;
            hold_q        <= hold_d;
            grant_count_q <= grant_count_d;
            bg_q          <= bg_d;
            mem_sel_q     <= mem_sel_d;
            cpu_stall_q   <= cpu_stall_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bg          = bg_q;
    assign mem_sel     = mem_sel_q;
    assign cpu_stall   = cpu_stall_q;
    assign timeout_err = timeout_q;
    assign grant_count = grant_count_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic,
// all compared against a behavioural ownership model.
module tb_bus_arbiter;

    localparam int CPU_SLOT = 2;
    localparam int MAX_HOLD = 64;
    localparam int CNT_W    = 16;

    logic             CLK;
    logic             reset_n;
    logic             dma_br;
    logic             cpu_req;
    logic             cpu_mem_busy;
    logic             bg;
    logic             mem_sel;
    logic             cpu_stall;
    logic             timeout_err;
    logic [CNT_W-1:0] grant_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who holds the bus and the bookkeeping the rules need.
    bit m_dma;
    bit m_rel;
    bit m_wait;
    bit m_timeout;
    bit m_stall;
    int m_slot;
    int m_held;
    int m_grants;

    bus_arbiter #(
        .CPU_SLOT(CPU_SLOT),
        .MAX_HOLD(MAX_HOLD),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .dma_br      (dma_br),
        .cpu_req     (cpu_req),
        .cpu_mem_busy(cpu_mem_busy),
        .bg          (bg),
        .mem_sel     (mem_sel),
        .cpu_stall   (cpu_stall),
        .timeout_err (timeout_err),
        .grant_count (grant_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        m_dma = 0; m_rel = 0; m_wait = 0; m_timeout = 0; m_stall = 0;
        m_slot = 0; m_held = 0; m_grants = 0;
    endfunction

    function automatic void modelGrant();
        m_dma  = 1;
        m_wait = 0;
        m_held = 0;
        m_grants++;
    endfunction

    function automatic void modelStep(input bit br, input bit req, input bit busy);
        bit may_take;
        may_take = (m_slot == 0) || !req;
        if (m_dma) begin
            if (!br) begin
                m_dma = 0;
                m_rel = 1;
            end else begin
                if (m_held < MAX_HOLD) m_held++;
                if (m_held >= MAX_HOLD) m_timeout = 1;
            end
        end else if (m_rel) begin
            m_rel  = 0;
            m_slot = CPU_SLOT;
        end else if (m_wait) begin
            if (!br) m_wait = 0;
            else if (!busy) modelGrant();
        end else begin
            if (m_slot > 0) m_slot = req ? m_slot - 1 : 0;
            if (br && may_take) begin
                m_slot = 0;
                if (busy) m_wait = 1;
                else modelGrant();
            end
        end
        m_stall = req && (m_dma || m_rel);
    endfunction

    // Called at a falling edge: drive inputs, let one rising edge pass, compare at the next falling edge.
    task automatic applyStimulus(input bit br, input bit req, input bit busy);
        dma_br       = br;
        cpu_req      = req;
        cpu_mem_busy = busy;
        @(posedge CLK);
        modelStep(br, req, busy);
        @(negedge CLK);
        checkOutput("bg",          32'(bg),          32'(m_dma));
        checkOutput("mem_sel",     32'(mem_sel),     32'(m_dma || m_rel));
        checkOutput("cpu_stall",   32'(cpu_stall),   32'(m_stall));
        checkOutput("timeout_err", 32'(timeout_err), 32'(m_timeout));
        checkOutput("grant_count", 32'(grant_count), 32'(m_grants % (1 << CNT_W)));
    endtask

    task automatic trackGap(inout bit seen_high, inout int low_run, inout int min_gap);
        if (bg) begin
            if (seen_high && (low_run < min_gap)) min_gap = low_run;
            seen_high = 1;
            low_run   = 0;
        end else begin
            low_run++;
        end
    endtask

    initial begin
        bit br_r;
        bit seen_high;
        int low_run;
        int min_gap;

        reset_n      = 1'b0;
        dma_br       = 1'b0;
        cpu_req      = 1'b0;
        cpu_mem_busy = 1'b0;
        modelReset();
        repeat (2) @(negedge CLK);
        checkOutput("rst_bg",          32'(bg),          32'd0);
        checkOutput("rst_mem_sel",     32'(mem_sel),     32'd0);
        checkOutput("rst_cpu_stall",   32'(cpu_stall),   32'd0);
        checkOutput("rst_timeout",     32'(timeout_err), 32'd0);
        checkOutput("rst_grant_count", 32'(grant_count), 32'd0);
        reset_n = 1'b1;

        $display("[TB] idle CPU, four-cycle DMA burst");
        repeat (4) applyStimulus(1, 0, 0);
        repeat (4) applyStimulus(0, 0, 0);
        checkOutput("s1_grants", 32'(grant_count), 32'd1);

        $display("[TB] DMA request during a CPU memory access");
        repeat (3) applyStimulus(1, 0, 1);
        repeat (3) applyStimulus(1, 0, 0);
        repeat (5) applyStimulus(0, 0, 0);
        checkOutput("s2_grants", 32'(grant_count), 32'd2);

        $display("[TB] busy CPU, back-to-back single-cycle DMA bursts");
        seen_high = 0; low_run = 0; min_gap = 1000;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(!m_dma, 1, 0);
            trackGap(seen_high, low_run, min_gap);
        end
        repeat (4) applyStimulus(0, 0, 0);
        checkOutput("s3_grants", 32'(grant_count), 32'd5);
        checkOutput("s3_gap_ok", 32'(min_gap >= 1 + CPU_SLOT), 32'd1);

        $display("[TB] idle CPU, DMA re-raises right after release");
        seen_high = 0; low_run = 0; min_gap = 1000;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(!m_dma, 0, 0);
            trackGap(seen_high, low_run, min_gap);
        end
        repeat (3) applyStimulus(0, 0, 0);
        checkOutput("s4_grants", 32'(grant_count), 32'd8);
        checkOutput("s4_gap", 32'(min_gap), 32'd2);

        $display("[TB] DMA holds the bus past the limit");
        repeat (75) applyStimulus(1, 1'($urandom_range(0, 1)), 0);
        repeat (3) applyStimulus(0, 0, 0);
        checkOutput("s5_timeout_sticky", 32'(timeout_err), 32'd1);

        $display("[TB] asynchronous reset while the DMA owns the bus");
        repeat (3) applyStimulus(1, 0, 0);
        repeat (2) applyStimulus(1, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_bg",          32'(bg),          32'd0);
        checkOutput("arst_mem_sel",     32'(mem_sel),     32'd0);
        checkOutput("arst_cpu_stall",   32'(cpu_stall),   32'd0);
        checkOutput("arst_timeout",     32'(timeout_err), 32'd0);
        checkOutput("arst_grant_count", 32'(grant_count), 32'd0);
        modelReset();
        @(negedge CLK);
        reset_n = 1'b1;
        applyStimulus(1, 0, 0);
        checkOutput("s6_regrant", 32'(bg), 32'd1);

        $display("[TB] random traffic");
        br_r = 1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) br_r = !br_r;
            applyStimulus(br_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
